// File: rtl/uart_boot_pkg.sv
// uart_boot_pkg: shared states, default sync bytes and header length for the UART boot loader.
package uart_boot_pkg;
    typedef enum logic [2:0] {RUN, SYNC, HDR, DATA, WRITE, WAIT_ON} state_t;
    localparam logic [7:0] DEF_STP = 8'hA5;
    localparam logic [7:0] DEF_ON = 8'h5A;
    localparam int HDR_LEN = 8;
    function automatic logic [3:0] be_mask(input logic [1:0] last_idx);
        return 4'b1111 >> (2'd3 - last_idx);
    endfunction
endpackage

// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if: RX byte stream, memory write bus and core control of the boot loader.
interface uart_boot_loader_if;
    logic [7:0] RxData;
    logic RxValid;
    logic RxReady;
    logic MemReq;
    logic MemGnt;
    logic MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWdata;
    logic [3:0] MemBe;
    logic CoreRst;
    logic Busy;
    modport master (
        input RxData, RxValid, MemGnt,
        output RxReady, MemReq, MemWe, MemAddr, MemWdata, MemBe, CoreRst, Busy
    );
    modport slave (
        output RxData, RxValid, MemGnt,
        input RxReady, MemReq, MemWe, MemAddr, MemWdata, MemBe, CoreRst, Busy
    );
endinterface

// File: rtl/boot_seq_detect.sv
// boot_seq_detect: flags the accepted byte that completes a run of SYNC_LEN consecutive matches.
module boot_seq_detect #(
    parameter int SYNC_LEN = 32
) (
    input logic Clk,
    input logic Rst,
    input logic [7:0] rx_data,
    input logic valid,
    input logic [7:0] match,
    input logic clr,
    output logic hit
);
    localparam int CW = $clog2(SYNC_LEN + 1);
    logic [CW-1:0] cnt;
    assign hit = valid && rx_data == match && cnt == CW'(SYNC_LEN - 1);
    always_ff @(posedge Clk)
        if (Rst || clr) cnt <= '0;
        else if (valid) cnt <= rx_data == match ? cnt + 1'b1 : '0;
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: parses the preamble/header/image byte stream, writes the image to memory
// and holds the core in reset while loading.
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter logic [7:0] STP_BYTE = DEF_STP,
    parameter logic [7:0] ON_BYTE = DEF_ON,
    parameter int SYNC_LEN = 32,
    parameter bit HOLD_AT_RESET = 1'b0
) (
    input logic Clk,
    input logic Rst,
    uart_boot_loader_if.master bus
);
    state_t state;
    logic [2:0] hdr_idx;
    logic [31:0] rem;
    logic [31:0] word;
    logic [1:0] byte_idx;
    logic accept, stp_hit, on_hit;
    logic [31:0] nxt_word;
    assign accept = bus.RxValid && bus.RxReady;
    assign nxt_word = word | (32'(bus.RxData) << {byte_idx, 3'b000});
    boot_seq_detect #(.SYNC_LEN(SYNC_LEN)) u_stp (
        .Clk(Clk), .Rst(Rst), .rx_data(bus.RxData), .valid(accept),
        .match(STP_BYTE), .clr(state != RUN), .hit(stp_hit)
    );
    boot_seq_detect #(.SYNC_LEN(SYNC_LEN)) u_on (
        .Clk(Clk), .Rst(Rst), .rx_data(bus.RxData), .valid(accept),
        .match(ON_BYTE), .clr(state != WAIT_ON), .hit(on_hit)
    );
    always_ff @(posedge Clk)
        if (Rst) begin
            state <= RUN;
            hdr_idx <= '0;
            rem <= '0;
            word <= '0;
            byte_idx <= '0;
            bus.RxReady <= 1'b1;
            bus.MemReq <= 1'b0;
            bus.MemWe <= 1'b0;
            bus.MemAddr <= '0;
            bus.MemWdata <= '0;
            bus.MemBe <= '0;
            bus.CoreRst <= HOLD_AT_RESET;
            bus.Busy <= 1'b0;
        end else case (state)
            RUN: if (stp_hit) begin
                bus.CoreRst <= 1'b1;
                bus.Busy <= 1'b1;
                state <= SYNC;
            end
            SYNC: if (accept && bus.RxData != STP_BYTE) begin
                bus.MemAddr <= {24'h0, bus.RxData[7:2], 2'b00};
                hdr_idx <= 3'd1;
                state <= HDR;
            end
            HDR: if (accept) begin
                hdr_idx <= hdr_idx + 1'b1;
                if (!hdr_idx[2]) bus.MemAddr[{hdr_idx[1:0], 3'b000} +: 8] <= bus.RxData;
                else rem[{hdr_idx[1:0], 3'b000} +: 8] <= bus.RxData;
                if (hdr_idx == 3'(HDR_LEN - 1)) begin
                    word <= '0;
                    byte_idx <= '0;
                    state <= {bus.RxData, rem[23:0]} == '0 ? WAIT_ON : DATA;
                end
            end
            DATA: if (accept) begin
                rem <= rem - 1'b1;
                if (byte_idx == 2'd3 || rem == 32'd1) begin
                    bus.MemReq <= 1'b1;
                    bus.MemWe <= 1'b1;
                    bus.MemWdata <= nxt_word;
                    bus.MemBe <= be_mask(byte_idx);
                    bus.RxReady <= 1'b0;
                    word <= '0;
                    byte_idx <= '0;
                    state <= WRITE;
                end else begin
                    word <= nxt_word;
                    byte_idx <= byte_idx + 1'b1;
                end
            end
            WRITE: if (bus.MemGnt) begin
                bus.MemReq <= 1'b0;
                bus.MemWe <= 1'b0;
                bus.MemAddr <= bus.MemAddr + 32'd4;
                bus.RxReady <= 1'b1;
                state <= rem == '0 ? WAIT_ON : DATA;
            end
            WAIT_ON: if (on_hit) begin
                bus.CoreRst <= 1'b0;
                bus.Busy <= 1'b0;
                state <= RUN;
            end
            default: state <= RUN;
        endcase
endmodule
